// File: rtl/mac_acumulador_pkg.sv
// mac_acumulador_pkg: Q8.8 format, constant table, operand encodings and saturation limits
package mac_acumulador_pkg;
  localparam int W = 16;
  localparam int FRAC = 8;
  localparam int AW = W + 4;
  localparam logic signed [W-1:0] C0 = 16'h0100;
  localparam logic signed [W-1:0] C1 = 16'h0080;
  localparam logic signed [W-1:0] C2 = 16'hFF00;
  localparam logic signed [W-1:0] C3 = 16'h0200;
  localparam logic signed [W-1:0] C4 = 16'h0040;
  localparam logic signed [W-1:0] C5 = 16'h0180;
  localparam int SAT_HI = (1 <<< (W - 1)) - 1;
  localparam int SAT_LO = -(1 <<< (W - 1));
  typedef enum logic [1:0] {F_X0, F_X1, F_X2, F_ZERO} fun_e;
  // indices 6 and 7 fall back to entry 0
  function automatic logic signed [W-1:0] const_sel(input logic [2:0] s);
    return s == 3'd1 ? C1 : s == 3'd2 ? C2 : s == 3'd3 ? C3 :
           s == 3'd4 ? C4 : s == 3'd5 ? C5 : C0;
  endfunction
endpackage

// File: rtl/mac_acumulador_sat_trunc.sv
// sat_trunc: clamps a wide signed value into a narrower signed range, flagging overflow
module sat_trunc
  import mac_acumulador_pkg::*;
#(
  parameter int IW = AW,
  parameter int OW = W,
  parameter int HI = SAT_HI,
  parameter int LO = SAT_LO
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [OW-1:0] q_o,
  output logic                 ovf_o
);
  localparam logic signed [IW-1:0] HI_V = IW'(HI);
  localparam logic signed [IW-1:0] LO_V = IW'(LO);
  logic hi, lo;
  assign hi = d_i > HI_V;
  assign lo = d_i < LO_V;
  assign ovf_o = hi | lo;
  assign q_o = hi ? HI_V[OW-1:0] : lo ? LO_V[OW-1:0] : d_i[OW-1:0];
endmodule

// File: rtl/mac_acumulador.sv
// mac_acumulador: two-stage constant*operand MAC; publishes the saturated Q8.8 sum on the last step
module mac_acumulador
  import mac_acumulador_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Bandera,
  input  logic [2:0]          sel_const,
  input  logic [1:0]          sel_fun,
  input  logic                sel_acum,
  input  logic                Band_Listo,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  output logic signed [W-1:0] y,
  output logic                y_valid,
  output logic                ovf
);
  logic signed [W-1:0] c_sel, f_sel, y_sat;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0] p_d, p_q, acc_d, acc_q;
  logic a_q, l_q, v_q, armed_q, fire, ovf_sat;
  assign c_sel = const_sel(sel_const);
  assign f_sel = sel_fun == F_X0 ? x0 : sel_fun == F_X1 ? x1 : sel_fun == F_X2 ? x2 : '0;
  assign prod = c_sel * f_sel;
  assign p_d = AW'(prod >>> FRAC);
  assign acc_d = a_q ? acc_q + p_q : p_q;
  // a load in the same cycle as the last step arms the output on its own
  assign fire = l_q & (armed_q | ~a_q);
  sat_trunc #(.IW(AW), .OW(W)) u_sat (.d_i(acc_d), .q_o(y_sat), .ovf_o(ovf_sat));
  // v_q marks a real captured step so reset/restart bubbles never arm the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      a_q <= 1'b0;
      l_q <= 1'b0;
      v_q <= 1'b0;
      acc_q <= '0;
      armed_q <= 1'b0;
      y <= '0;
      ovf <= 1'b0;
      y_valid <= 1'b0;
    end else if (Bandera) begin
      p_q <= '0;
      a_q <= 1'b0;
      l_q <= 1'b0;
      v_q <= 1'b0;
      acc_q <= '0;
      armed_q <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      p_q <= p_d;
      a_q <= sel_acum;
      l_q <= Band_Listo;
      v_q <= 1'b1;
      acc_q <= acc_d;
      armed_q <= armed_q | (v_q & ~a_q);
      y_valid <= fire;
      if (fire) begin
        y <= y_sat;
        ovf <= ovf_sat;
      end
    end
  end
endmodule
